// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between NUM_REQ requesters.
// Read data is steered back to its issuer RD_LATENCY cycles after acceptance.
module bram_port_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_BITW  = 32,
    parameter int DATA_BITW  = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                           Clk_C,
    input  logic                           Rst_R,
    input  logic [NUM_REQ-1:0]             Req_S,
    input  logic [NUM_REQ*ADDR_BITW-1:0]   Addr_S,
    input  logic [NUM_REQ*DATA_BITW/8-1:0] WrEn_S,
    input  logic [NUM_REQ*DATA_BITW-1:0]   Wr_D,
    output logic [NUM_REQ-1:0]             Gnt_S,
    output logic [NUM_REQ-1:0]             RdValid_S,
    output logic [DATA_BITW-1:0]           Rd_D,
    output logic                           Bram_Clk_C,
    output logic                           Bram_Rst_R,
    output logic                           Bram_En_S,
    output logic [ADDR_BITW-1:0]           Bram_Addr_S,
    output logic [DATA_BITW/8-1:0]         Bram_WrEn_S,
    output logic [DATA_BITW-1:0]           Bram_Wr_D,
    input  logic [DATA_BITW-1:0]           Bram_Rd_D
);

    localparam int BE_BITW = DATA_BITW / 8;
    localparam int ID_BITW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ID_BITW-1:0]   prio_q, prio_d;
    logic                 win_valid;
    logic [ID_BITW-1:0]   win_id;
    int                   best_dist;
    logic [NUM_REQ-1:0]   gnt;
    logic [ADDR_BITW-1:0] sel_addr;
    logic [BE_BITW-1:0]   sel_we;
    logic [DATA_BITW-1:0] sel_wd;

    logic [RD_LATENCY-1:0] rd_vld_q, rd_vld_d;
    logic [ID_BITW-1:0]    rd_id_q [RD_LATENCY];
    logic [ID_BITW-1:0]    rd_id_d [RD_LATENCY];

    // Winner is the requester closest to the pointer going upward (mod NUM_REQ).
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        best_dist = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (Req_S[i] && (((i + NUM_REQ - int'(prio_q)) % NUM_REQ) < best_dist)) begin
                best_dist = (i + NUM_REQ - int'(prio_q)) % NUM_REQ;
                win_id    = ID_BITW'(i);
                win_valid = 1'b1;
            end
        end
        if (Rst_R) begin
            win_valid = 1'b0;
        end
    end

    always_comb begin
        gnt      = '0;
        sel_addr = '0;
        sel_we   = '0;
        sel_wd   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_valid && (win_id == ID_BITW'(i))) begin
                gnt[i]   = 1'b1;
                sel_addr = Addr_S[i*ADDR_BITW +: ADDR_BITW];
                sel_we   = WrEn_S[i*BE_BITW +: BE_BITW];
                sel_wd   = Wr_D[i*DATA_BITW +: DATA_BITW];
            end
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (win_valid) begin
            prio_d = (win_id == ID_BITW'(NUM_REQ - 1)) ? '0 : win_id + ID_BITW'(1);
        end
        rd_vld_d[0] = win_valid && (sel_we == '0);
        rd_id_d[0]  = win_id;
        for (int s = 1; s < RD_LATENCY; s++) begin
            rd_vld_d[s] = rd_vld_q[s-1];
            rd_id_d[s]  = rd_id_q[s-1];
        end
    end

    always_ff @(posedge Clk_C or posedge Rst_R) begin
        if (Rst_R) begin
            prio_q   <= '0;
            rd_vld_q <= '0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                rd_id_q[s] <= '0;
            end
        end else begin
            prio_q   <= prio_d;
            rd_vld_q <= rd_vld_d;
            for (int s = 0; s < RD_LATENCY; s++) begin
                rd_id_q[s] <= rd_id_d[s];
            end
        end
    end

    always_comb begin
        RdValid_S = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rd_vld_q[RD_LATENCY-1] && (rd_id_q[RD_LATENCY-1] == ID_BITW'(i))) begin
                RdValid_S[i] = 1'b1;
            end
        end
    end

    assign Gnt_S       = gnt;
    assign Rd_D        = Bram_Rd_D;
    assign Bram_Clk_C  = Clk_C;
    assign Bram_Rst_R  = Rst_R;
    assign Bram_En_S   = win_valid;
    assign Bram_Addr_S = sel_addr;
    assign Bram_WrEn_S = sel_we;
    assign Bram_Wr_D   = sel_wd;

endmodule
